magcomp_serial: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, starting at the most-significant slice, and stops at the first slice that differs. It supports unsigned and two's-complement modes and uses a start/done handshake. It is the sequential successor to the team's 2-bit combinational comparator and is meant for datapaths where area matters more than single-cycle latency.

---
 rtl/magcomp_serial.sv | 113 +++++++++++
 tb/tb_magcomp_serial.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magcomp_serial.sv
// ============================================================================
// Module   : magcomp_serial
// Purpose  : Multi-cycle magnitude comparator, one DIGIT-bit slice per clock,
//            MSB slice first, early exit on the first differing slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module magcomp_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             AGB,
    output logic             AEB,
    output logic             ALB
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] c_idx_msb  = IDXW'(NDIG - 1);
    localparam logic [IDXW-1:0] c_idx_zero = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_agb;
    logic             r_aeb;
    logic             r_alb;

    logic [WIDTH-1:0] w_sign_flip;
    logic [DIGIT-1:0] w_a_slice;
    logic [DIGIT-1:0] w_b_slice;

    // Flipping the MSB maps two's-complement ordering onto unsigned ordering.
    assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    assign w_a_slice   = r_a[DIGIT*int'(r_idx) +: DIGIT];
    assign w_b_slice   = r_b[DIGIT*int'(r_idx) +: DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= c_idx_zero;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_agb   <= 1'b0;
            r_aeb   <= 1'b0;
            r_alb   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A ^ w_sign_flip;
                        r_b     <= B ^ w_sign_flip;
                        r_idx   <= c_idx_msb;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_a_slice != w_b_slice) begin
                        r_agb   <= (w_a_slice > w_b_slice);
                        r_alb   <= (w_a_slice < w_b_slice);
                        r_aeb   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_idx == c_idx_zero) begin
                        r_agb   <= 1'b0;
                        r_alb   <= 1'b0;
                        r_aeb   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign AGB  = r_agb;
    assign AEB  = r_aeb;
    assign ALB  = r_alb;

endmodule

`default_nettype wire

// File: tb/tb_magcomp_serial.sv
// ============================================================================
// Module   : tb_magcomp_serial
// Purpose  : Scoreboard bench for magcomp_serial (WIDTH=8, DIGIT=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magcomp_serial;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    typedef struct {
        logic [2:0] flags;   // {AGB, AEB, ALB}
        int         acc;
        int         m;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic         AGB;
    logic         AEB;
    logic         ALB;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   blen  = 0;
    exp_t q[$];

    magcomp_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .AGB         (AGB),
        .AEB         (AEB),
        .ALB         (ALB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t       e;
        logic [W-1:0] d;
        logic       gt;
        logic       lt;
        d   = a ^ b;
        e.m = NDIG;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (d[i*D +: D] != '0) begin
                e.m = NDIG - i;
                break;
            end
        end
        if (s) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        e.flags = {gt, (a == b), lt};
        e.acc   = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse and checks flags, latency, busy length.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            blen = 0;
        end else begin
            if (busy) blen++;
            if (done) begin
                chk("busy_with_done", int'(busy), 0);
                chk("done_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("flags", int'({AGB, AEB, ALB}), int'(e.flags));
                    chk("latency", cyc - e.acc, e.m);
                    chk("busy_len", blen, e.m);
                end
                blen = 0;
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e     = model(a, b, s);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #1;
        A = a; B = b; signed_mode = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(a, b, s);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) return;
            @(posedge clk);
        end
        chk("timeout_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        issue(a, b, s);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({AGB, AEB, ALB}), 0);
        rst = 1'b0;

        // Directed cases
        cmp(8'hA5, 8'h25, 1'b0);
        cmp(8'h12, 8'h13, 1'b0);
        cmp(8'h3C, 8'h3C, 1'b0);
        cmp(8'h80, 8'h01, 1'b1);
        cmp(8'h80, 8'h01, 1'b0);
        cmp(8'hFF, 8'hFE, 1'b1);

        // Second start and operand changes during SCAN must not disturb the compare
        @(posedge clk); #1;
        A = 8'h00; B = 8'h00; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        A = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 8'h55; B = 8'hAA; signed_mode = 1'b1;
        wait_idle();
        repeat (4) @(posedge clk);

        // Reset mid-SCAN aborts the compare and clears the flags
        issue(8'h3C, 8'h3C, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_flags", int'({AGB, AEB, ALB}), 0);
        repeat (5) @(posedge clk);

        // rst together with start: start is not accepted
        #1;
        A = 8'h01; B = 8'h02; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_idle", int'(busy), 0);

        // Back-to-back with start held high
        @(posedge clk); #1;
        A = 8'hC0; B = 8'h40; signed_mode = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            push_exp(8'hC0, 8'h40, 1'b0);
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        wait_idle();

        // Randomised sweep biased toward shared high slices to spread latencies
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2500; i++) begin
                logic [W-1:0] a;
                logic [W-1:0] mask;
                logic [W-1:0] r;
                a = W'($urandom);
                r = W'($urandom);
                case ($urandom_range(0, 3))
                    0: mask = 8'hFF;
                    1: mask = 8'h0F;
                    2: mask = 8'h03;
                    default: mask = 8'h00;
                endcase
                cmp(a, a ^ (r & mask), s[0]);
            end
        end
        cmp(8'h7F, 8'h80, 1'b1);
        cmp(8'h7F, 8'h80, 1'b0);
        cmp(8'h00, 8'hFF, 1'b1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
